pwl_transform_pipe: RTL and testbench
=====================================

Name: pwl_transform_pipe

Overview:
- Parametrised piecewise-linear transfer-curve block for the pixel/colour path; successor to the fixed 16-segment linear transformation block.
- Segment count is a parameter. Breakpoints are uniformly spaced across the input range. Knot values are loaded at runtime through a config port.
- Slopes are computed by an internal FSM into a double-buffered table, so a curve update never disturbs the streaming datapath.
- Sits between the colour-space stage and downstream thresholding. Fully pipelined, one sample per clock, no backpressure.

Parameters:
DSIZE, 12, input/output sample width (unsigned)
SEG_BITS, 4, log2 of segment count; NSEG = 2^SEG_BITS; legal range 1..DSIZE-1
W (local), DSIZE-SEG_BITS, offset width within a segment

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  knot write strobe
cfg_addr  in  SEG_BITS+1  knot index 0..NSEG
cfg_wdata  in  DSIZE  knot value C[cfg_addr]
cfg_commit  in  1  pulse: build slopes from shadow knots and swap tables
cfg_busy  out  1  commit in progress
cal_valid  out  1  a committed table is active
in_valid  in  1  input sample strobe
indata  in  DSIZE  input sample
out_valid  out  1  output sample strobe
outdata  out  DSIZE  transformed sample

Behaviour:
- Reset values: shadow knots, both table banks and bank_sel = 0; cal_valid = 0; cfg_busy = 0; out_valid = 0; outdata = 0; pipeline valids = 0; FSM = IDLE.
- Shadow knots: NSEG+1 registers.
  - Written on cfg_we only when FSM is IDLE.
  - A write with cfg_addr > NSEG is ignored.
  - A write while busy is ignored.
- FSM states: IDLE -> CALC -> SWAP -> IDLE.
  - IDLE: a cfg_commit in cycle t enters CALC at t+1. cfg_commit while not IDLE is ignored.
  - A cfg_we and cfg_commit in the same IDLE cycle: the write lands first, and CALC uses the written value.
  - CALC: counter k = 0..NSEG-1, one entry per cycle. Standby bank gets C_s[k] = shadow[k] and D_s[k] = shadow[k+1]-shadow[k], signed, DSIZE+1 bits. Occupies cycles t+1..t+NSEG.
  - SWAP: cycle t+NSEG+1. bank_sel toggles and cal_valid is set to 1 (it stays 1 until reset).
  - cfg_busy = 1 in CALC and SWAP, i.e. t+1..t+NSEG+1.
- Datapath: 3-stage pipeline. out_valid(n+3) = in_valid(n). outdata holds its value when out_valid = 0.
  - S1: seg = indata[DSIZE-1:W], off = indata[W-1:0]. Register C[seg], D[seg], off and cal_valid from the active bank. This lookup is the only point the bank is sampled.
    - Samples captured before the swap edge complete entirely with the old table; later samples use the new one.
    - No sample ever mixes banks.
  - S2: p = D x off. D is signed; off is zero-extended. Result is DSIZE+1+W bits signed.
  - S3: r = (p + 2^(W-1)) >>> W (arithmetic shift). y = C + r, clamped to [0, 2^DSIZE-1].
    - If the captured cal_valid is 0, y = the captured indata (identity passthrough, same latency).
- The top knot C[NSEG] defines only the last slope and is never output directly (max off = 2^W-1).
- Reset mid-CALC: the FSM aborts to IDLE and all tables are cleared. cal_valid = 0, so the datapath passes through.
- in_valid gaps are allowed. Pipeline stages advance every cycle; valids are carried alongside the data.

Test Plan:
- No commit: stream indata 0x000, 0x7A5, 0xFFF -> out_valid 3 cycles later; outdata 0x000, 0x7A5, 0xFFF; cal_valid = 0.
- Identity load (DSIZE 12, SEG_BITS 4): C[k] = 256k for k = 0..15, C[16] = 4095; commit -> cfg_busy high for 17 cycles, cal_valid rises on cycle 18. indata 0x123 -> 0x123; indata 0xFFF -> 4095 - 256 + 255 = 0xFFE... (C15 = 3840, D = 255, off = 255: 3840 + round(65025/256) = 3840 + 254 = 4094).
- Falling curve: C[0] = 4095, C[1] = 3839 -> indata 0x080 gives p = -32768, r = floor(-32640/256) = -128, outdata = 3967.
- Swap mid-stream: continuous in_valid with table A = identity, commit table B = inverted. Every output equals exactly A(x) or B(x); switchover is at the first sample captured after SWAP. No dropped or duplicated out_valid.
- Writes and a second cfg_commit during cfg_busy, plus cfg_addr = 17 -> all ignored; shadow and resulting table unchanged.
- Assert rst_n low at CALC k = 5 -> cfg_busy = 0 and cal_valid = 0 immediately; after release, indata 0x456 -> 0x456 passthrough.

Source files
------------

// File: rtl/pwl_transform_pipe.sv
// Piecewise-linear transfer curve with runtime-loaded knots. Slopes are built into a
// standby bank by a small FSM and swapped in atomically; datapath is a 3-stage pipe.
module pwl_transform_pipe #(
  parameter int DSIZE    = 12,
  parameter int SEG_BITS = 4
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [SEG_BITS:0]   cfg_addr,
  input  logic [DSIZE-1:0]    cfg_wdata,
  input  logic                cfg_commit,
  output logic                cfg_busy,
  output logic                cal_valid,
  input  logic                in_valid,
  input  logic [DSIZE-1:0]    indata,
  output logic                out_valid,
  output logic [DSIZE-1:0]    outdata
);

  localparam int NSEG = 1 << SEG_BITS;
  localparam int W    = DSIZE - SEG_BITS;
  localparam int AW   = SEG_BITS + 1;
  localparam int PW   = DSIZE + 1 + W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SWAP = 2'd2;

  localparam logic signed [PW-1:0] Y_MAX = PW'((1 << DSIZE) - 1);
  localparam logic signed [PW-1:0] HALF  = PW'(1 << (W - 1));

  logic [DSIZE-1:0]        shadow [NSEG+1];
  logic [DSIZE-1:0]        c_tab  [2][NSEG];
  logic signed [DSIZE:0]   d_tab  [2][NSEG];
  logic                    bank_sel;
  logic [1:0]              state;
  logic [AW-1:0]           k;
  logic [AW-1:0]           k_next;
  logic signed [DSIZE:0]   diff;

  assign k_next   = k + 1'b1;
  assign diff     = $signed({1'b0, shadow[k_next]}) - $signed({1'b0, shadow[k]});
  assign cfg_busy = (state != ST_IDLE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      bank_sel  <= 1'b0;
      cal_valid <= 1'b0;
      for (int unsigned i = 0; i <= NSEG; i++) shadow[i] <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < NSEG; i++) begin
          c_tab[b][i] <= '0;
          d_tab[b][i] <= '0;
        end
      end
    end else begin
      case (state)
        ST_IDLE: begin
          // write lands on the same edge the commit is accepted, so CALC sees it
          if (cfg_we && (cfg_addr <= AW'(NSEG))) shadow[cfg_addr] <= cfg_wdata;
          if (cfg_commit) begin
            state <= ST_CALC;
            k     <= '0;
          end
        end
        ST_CALC: begin
          c_tab[~bank_sel][k[SEG_BITS-1:0]] <= shadow[k];
          d_tab[~bank_sel][k[SEG_BITS-1:0]] <= diff;
          if (k == AW'(NSEG - 1)) state <= ST_SWAP;
          else                    k     <= k_next;
        end
        ST_SWAP: begin
          bank_sel  <= ~bank_sel;
          cal_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [SEG_BITS-1:0]     seg;
  logic [W-1:0]            off;
  logic                    s1_v, s1_cal, s2_v, s2_cal;
  logic [DSIZE-1:0]        s1_x, s1_c, s2_x, s2_c;
  logic signed [DSIZE:0]   s1_d;
  logic [W-1:0]            s1_off;
  logic signed [PW-1:0]    s2_p;
  logic signed [PW-1:0]    d_ext, off_ext, prod;
  logic signed [PW-1:0]    rnd, shifted, c_ext, y_s;
  logic [DSIZE-1:0]        y_clamp;

  assign seg = indata[DSIZE-1:W];
  assign off = indata[W-1:0];

  always_comb begin
    d_ext   = PW'(s1_d);
    off_ext = PW'(s1_off);
    prod    = d_ext * off_ext;
  end

  always_comb begin
    rnd     = s2_p + HALF;
    shifted = rnd >>> W;
    c_ext   = PW'(s2_c);
    y_s     = c_ext + shifted;
    y_clamp = y_s[DSIZE-1:0];
    if (y_s < 0)          y_clamp = '0;
    else if (y_s > Y_MAX) y_clamp = '1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_cal    <= 1'b0;
      s1_x      <= '0;
      s1_c      <= '0;
      s1_d      <= '0;
      s1_off    <= '0;
      s2_v      <= 1'b0;
      s2_cal    <= 1'b0;
      s2_x      <= '0;
      s2_c      <= '0;
      s2_p      <= '0;
      out_valid <= 1'b0;
      outdata   <= '0;
    end else begin
      // the only sampling point of bank_sel/cal_valid, so a sample never mixes banks
      s1_v      <= in_valid;
      s1_cal    <= cal_valid;
      s1_x      <= indata;
      s1_c      <= c_tab[bank_sel][seg];
      s1_d      <= d_tab[bank_sel][seg];
      s1_off    <= off;
      s2_v      <= s1_v;
      s2_cal    <= s1_cal;
      s2_x      <= s1_x;
      s2_c      <= s1_c;
      s2_p      <= prod;
      out_valid <= s2_v;
      if (s2_v) outdata <= s2_cal ? y_clamp : s2_x;
    end
  end

endmodule

// File: tb/tb_pwl_transform_pipe.sv
// Bench for pwl_transform_pipe: table vectors, hand-written commit/reset sequences and
// randomized streams scored against a knot-level arithmetic model.
module tb_pwl_transform_pipe;

  localparam int DSIZE = 12;
  localparam int SEG_BITS = 4;
  localparam int NSEG = 16;
  localparam int W = 8;
  localparam int AW = 5;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [DSIZE-1:0] cfg_wdata = '0;
  logic             cfg_commit = 1'b0;
  logic             cfg_busy, cal_valid, out_valid;
  logic             in_valid = 1'b0;
  logic [DSIZE-1:0] indata = '0;
  logic [DSIZE-1:0] outdata;

  pwl_transform_pipe #(.DSIZE(DSIZE), .SEG_BITS(SEG_BITS)) dut (
    .clock(clock), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .cal_valid(cal_valid), .in_valid(in_valid), .indata(indata),
    .out_valid(out_valid), .outdata(outdata)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int due; int y; } exp_t;
  exp_t q[$];

  // model: shadow knots, active knots, pending knots, cycles until the swap
  int sh[NSEG+1];
  int act[NSEG+1];
  int pend[NSEG+1];
  bit act_v = 1'b0;
  int cd = 0;

  typedef struct { logic [DSIZE-1:0] x; logic [DSIZE-1:0] y; } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at cycle %0d", nm, got, want, cyc);
    end
  endtask

  function automatic int floor_div(input int n, input int d);
    int r;
    r = n / d;
    if ((n % d) != 0 && n < 0) r--;
    return r;
  endfunction

  function automatic int ref_y(input int x);
    int seg, off, c, d, y;
    if (!act_v) return x;
    seg = x / (1 << W);
    off = x % (1 << W);
    c = act[seg];
    d = act[seg+1] - act[seg];
    y = c + floor_div(d * off + (1 << (W-1)), 1 << W);
    if (y < 0) y = 0;
    if (y > (1 << DSIZE) - 1) y = (1 << DSIZE) - 1;
    return y;
  endfunction

  task automatic step(input bit v, input int x, input int ex,
                      input bit we = 1'b0, input int a = 0, input int wd = 0,
                      input bit cm = 1'b0);
    in_valid = v;
    indata = DSIZE'(x);
    cfg_we = we;
    cfg_addr = AW'(a);
    cfg_wdata = DSIZE'(wd);
    cfg_commit = cm;
    if (v) q.push_back('{due: cyc + 3, y: ex});
    @(posedge clock);
    #1;
    if (cd == 0) begin
      if (we && a <= NSEG) sh[a] = wd;
      if (cm) begin
        cd = NSEG + 1;
        pend = sh;
      end
    end else begin
      cd--;
      if (cd == 0) begin
        act = pend;
        act_v = 1'b1;
      end
    end
    chk("busy", int'(cfg_busy), int'(cd > 0));
    chk("cal_valid", int'(cal_valid), int'(act_v));
    in_valid = 1'b0;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic samp(input bit v, input int x);
    step(v, x, ref_y(x));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0);
  endtask

  task automatic load(input int kn[NSEG+1], input bit dense);
    int x;
    for (int i = 0; i <= NSEG; i++) begin
      x = int'($urandom_range(0, (1 << DSIZE) - 1));
      step(dense || ($urandom_range(0, 1) == 1), x, ref_y(x), 1'b1, i, kn[i]);
    end
  endtask

  // random stream; while the model says busy, also throw ignored writes/commits
  task automatic stream(input int n, input int pct);
    int x;
    bit v, g_we, g_cm;
    for (int i = 0; i < n; i++) begin
      x = int'($urandom_range(0, (1 << DSIZE) - 1));
      v = ($urandom_range(0, 99) < pct);
      g_we = (cd > 0) && ($urandom_range(0, 1) == 1);
      g_cm = (cd > 0) && ($urandom_range(0, 1) == 1);
      step(v, x, ref_y(x), g_we, int'($urandom_range(0, 31)),
           int'($urandom_range(0, 4095)), g_cm);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    bit due;
    int last_out;
    if (!rst_n) begin
      last_out = 0;
    end else begin
      due = (q.size() > 0) && (q[0].due == cyc);
      chk("out_valid", int'(out_valid), int'(due));
      if (due) begin
        e = q.pop_front();
        chk("outdata", int'(outdata), e.y);
        last_out = e.y;
      end else begin
        chk("hold", int'(outdata), last_out);
      end
    end
  end

  initial begin
    int kn[NSEG+1];
    int busy_n, rise;
    for (int i = 0; i <= NSEG; i++) begin
      sh[i] = 0;
      act[i] = 0;
      pend[i] = 0;
    end
    vecs[0] = '{x: 12'h123, y: 12'h123};
    vecs[1] = '{x: 12'hFFF, y: 12'hFFE};
    vecs[2] = '{x: 12'h000, y: 12'h000};
    vecs[3] = '{x: 12'h7A5, y: 12'h7A5};
    vecs[4] = '{x: 12'h0FF, y: 12'h0FF};
    vecs[5] = '{x: 12'hF00, y: 12'hF00};
    vecs[6] = '{x: 12'hEFF, y: 12'hEFF};
    vecs[7] = '{x: 12'h100, y: 12'h100};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_cal_valid", int'(cal_valid), 0);
    chk("rst_busy", int'(cfg_busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_outdata", int'(outdata), 0);
    rst_n = 1'b1;
    idle(2);

    // passthrough before any commit
    step(1'b1, 12'h000, 12'h000);
    step(1'b1, 12'h7A5, 12'h7A5);
    step(1'b1, 12'hFFF, 12'hFFF);
    idle(4);

    // identity curve; measure busy window and cal_valid rise
    for (int i = 0; i < NSEG; i++) kn[i] = 256 * i;
    kn[NSEG] = 4095;
    load(kn, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    busy_n = 0;
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      if (cfg_busy) busy_n++;
      if (cal_valid && rise < 0) rise = i;
      step(1'b0, 0, 0);
    end
    chk("busy_len", busy_n, 17);
    chk("cal_rise", rise, 17);
    for (int i = 0; i < 8; i++) step(1'b1, int'(vecs[i].x), int'(vecs[i].y));
    idle(4);

    // inverted curve committed under continuous traffic, garbage during busy
    for (int i = 0; i < NSEG; i++) kn[i] = 4095 - 256 * i;
    kn[NSEG] = 0;
    load(kn, 1'b1);
    begin
      int x;
      x = int'($urandom_range(0, 4095));
      step(1'b1, x, ref_y(x), 1'b0, 0, 0, 1'b1);
    end
    stream(30, 100);
    step(1'b0, 0, 0, 1'b1, 17, 1234);
    step(1'b0, 0, 0, 1'b1, 31, 999);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    stream(30, 100);
    idle(4);

    // random curves
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i <= NSEG; i++) kn[i] = int'($urandom_range(0, 4095));
      load(kn, 1'b0);
      step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
      stream(80, 70);
    end
    idle(4);

    // falling first segment, write and commit in the same cycle for knot 1
    step(1'b0, 0, 0, 1'b1, 0, 4095);
    step(1'b0, 0, 0, 1'b1, 1, 3839, 1'b1);
    idle(NSEG + 2);
    step(1'b1, 12'h080, 3967);
    idle(4);

    // reset in the middle of CALC (k = 5)
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    idle(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(cfg_busy), 0);
    chk("midrst_cal_valid", int'(cal_valid), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    cd = 0;
    act_v = 1'b0;
    for (int i = 0; i <= NSEG; i++) begin
      sh[i] = 0;
      act[i] = 0;
    end
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    step(1'b1, 12'h456, 12'h456);
    idle(5);

    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
